// File: rtl/seven_seg_scan_ctrl.sv
// 4-digit display sequencer: valid/ready value intake, one bin_to_bcd
// conversion per value, frame-aligned commit and blanked digit scan.
// Ports: clk, rst (sync, active-high); value_in/value_valid/value_ready,
// overflow, conv_error; bcd_start/bcd_value_bin/bcd_value/bcd_done to
// the converter; cathodes (active-low), digit_bcd, digit_blank, frame_tick.
// Option macro SEVEN_SEG_LZ_BLANK_EN: blank leading-zero digits 3..1.
module seven_seg_scan_ctrl #(
  parameter int SCAN_DIV_W   = 14,
  parameter int BLANK_CYCLES = 16,
  parameter int CONV_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] value_in,
  input  logic        value_valid,
  output logic        value_ready,
  output logic        overflow,
  output logic        conv_error,
  output logic        bcd_start,
  output logic [13:0] bcd_value_bin,
  input  logic [19:0] bcd_value,
  input  logic        bcd_done,
  output logic [3:0]  cathodes,
  output logic [3:0]  digit_bcd,
  output logic        digit_blank,
  output logic        frame_tick
);

  localparam int TW = $clog2(CONV_TIMEOUT + 1);
  localparam logic [SCAN_DIV_W-1:0] BLANK =
    SCAN_DIV_W'(BLANK_CYCLES);
  localparam logic [TW-1:0] TMO_LAST =
    TW'(CONV_TIMEOUT - 1);
  localparam logic [13:0] MAX_VAL = 14'd9999;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    PEND
  } state_t;

  state_t                  state;
  logic [SCAN_DIV_W-1:0]   cnt;
  logic [1:0]              idx;
  logic [15:0]             disp;
  logic [15:0]             pend;
  logic [TW-1:0]           tmo;
  logic                    wrap;
  logic                    gap;
  logic                    accept;
  logic                    over_lim;
  logic                    lz;
  logic                    unused_bcd_hi;

  assign wrap     = &cnt;
  assign gap      = cnt < BLANK;
  assign accept   = value_valid & value_ready;
  assign over_lim = value_in > MAX_VAL;
  assign unused_bcd_hi = ^bcd_value[19:16];

  // Free-running scan, never stalled by the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      frame_tick <= 1'b0;
    end else begin
      cnt        <= cnt + 1'b1;
      frame_tick <= wrap && (idx == 2'd3);
      if (wrap) idx <= idx + 1'b1;
    end
  end

`ifdef SEVEN_SEG_LZ_BLANK_EN
  // lead[i]: digit i and everything above it are zero.
  logic [3:0] lead;
  always_comb begin
    lead    = '0;
    lead[3] = disp[15:12] == 4'd0;
    lead[2] = lead[3] && (disp[11:8] == 4'd0);
    lead[1] = lead[2] && (disp[7:4] == 4'd0);
  end
  assign lz = lead[idx];
`else
  assign lz = 1'b0;
`endif

  assign cathodes    = gap ? 4'b1111 : ~(4'b0001 << idx);
  assign digit_bcd   = disp[{idx, 2'b00} +: 4];
  assign digit_blank = gap | lz;

  // Commit only on frame_tick, i.e. inside the index-0 blanking gap,
  // so a frame never mixes old and new digits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      value_ready   <= 1'b0;
      bcd_start     <= 1'b0;
      overflow      <= 1'b0;
      conv_error    <= 1'b0;
      bcd_value_bin <= '0;
      disp          <= '0;
      pend          <= '0;
      tmo           <= '0;
    end else begin
      bcd_start <= 1'b0;
      unique case (state)
        IDLE: begin
          value_ready <= 1'b1;
          if (accept) begin
            bcd_value_bin <= over_lim ? MAX_VAL : value_in;
            overflow      <= over_lim;
            conv_error    <= 1'b0;
            bcd_start     <= 1'b1;
            tmo           <= '0;
            value_ready   <= 1'b0;
            state         <= CONV;
          end
        end
        CONV: begin
          tmo <= tmo + 1'b1;
          // done alongside the start pulse is stale
          if (bcd_done && !bcd_start) begin
            pend  <= bcd_value[15:0];
            state <= PEND;
          end else if (tmo == TMO_LAST) begin
            conv_error  <= 1'b1;
            value_ready <= 1'b1;
            state       <= IDLE;
          end
        end
        PEND: begin
          if (frame_tick) begin
            disp        <= pend;
            value_ready <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
